inst_mem_pipe: RTL and testbench

Parametrised, writable, pipelined instruction memory that replaces the fixed combinational instruction table.
- PC-addressed fetch with valid/ready handshake on both the request and response sides.
- Configurable read latency.
- Program-load write port, so instruction images are loaded at run time instead of being hard-coded.
- Explicit error flags for misaligned and out-of-range PCs.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

---
 rtl/inst_mem_pipe.sv | 119 +++++++++++
 tb/tb_inst_mem_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe.sv
// Writable, pipelined instruction memory between the IF PC register and IF/ID.
// Clears itself to NOP_WORD after reset, then serves PC fetches with a fixed latency.
module inst_mem_pipe #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 256,
  parameter int               ADDR_W   = 32,
  parameter int               LATENCY  = 1,
  parameter logic [WIDTH-1:0] NOP_WORD = {WIDTH{1'b0}},
  localparam int              IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_err,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  output logic              init_done,
  output logic              dbg_state
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  logic             r_init_done;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic              r_vld   [LATENCY];
  logic [WIDTH-1:0]  r_instr [LATENCY];
  logic [ADDR_W-1:0] r_pc    [LATENCY];
  logic [1:0]        r_err   [LATENCY];

  logic             w_run;
  logic             w_adv;
  logic             w_accept;
  logic             w_mis;
  logic             w_oob;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_fetch;

  // Handshake: a transfer happens on a cycle where valid and ready are both high;
  // a response, once valid, holds all its fields until rsp_ready takes it.
  assign w_run     = (r_state == S_RUN);
  assign w_adv     = !rsp_valid || rsp_ready;
  assign req_ready = w_run && w_adv && !prog_we && !flush;
  assign w_accept  = req_valid && req_ready;

  assign w_idx   = req_pc[IDX_W+1:2];
  assign w_mis   = |req_pc[1:0];
  assign w_oob   = |req_pc[ADDR_W-1:IDX_W+2];
  assign w_fetch = (w_mis || w_oob) ? NOP_WORD : r_mem[w_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
        r_state     <= S_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // The array has no reset; the sweep rewrites it, and program writes only land in RUN.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_cnt] <= NOP_WORD;
    end else if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]   <= 1'b0;
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_err[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_instr[0] <= w_fetch;
        r_pc[0]    <= req_pc;
        r_err[0]   <= {w_oob, w_mis};
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_instr[i] <= r_instr[i-1];
        r_pc[i]    <= r_pc[i-1];
        r_err[i]   <= r_err[i-1];
      end
    end
  end

  assign rsp_valid = r_vld[LATENCY-1];
  assign rsp_instr = r_instr[LATENCY-1];
  assign rsp_pc    = r_pc[LATENCY-1];
  assign rsp_err   = r_err[LATENCY-1];
  assign init_done = r_init_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: one instance with LATENCY=2 and one with LATENCY=3,
// each with its own stimulus signals and its own expected-response queue.
module tb_inst_mem_pipe;

  localparam logic [31:0] W0   = 32'h8001060A;
  localparam logic [31:0] W1   = 32'h04011000;
  localparam logic [31:0] W2   = 32'h0C011800;
  localparam logic [31:0] W3   = 32'h14432000;
  localparam logic [31:0] NEWW = 32'hDEADBEEF;
  localparam int          NV   = 9;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  err;
    logic [31:0] acc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_pc    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_instr [2];
  logic [31:0] rsp_pc    [2];
  logic [1:0]  rsp_err   [2];
  logic        prog_we   [2];
  logic [7:0]  prog_addr [2];
  logic [31:0] prog_data [2];
  logic        flush     [2];
  logic        init_done [2];
  logic        dbg_state [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_chk [2];
  int   lat_of  [2];
  vec_t vec     [NV];
  logic [31:0] words [4];

  inst_mem_pipe #(.WIDTH(32), .DEPTH(256), .ADDR_W(32), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_pc(req_pc[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
    .rsp_pc(rsp_pc[0]), .rsp_err(rsp_err[0]),
    .prog_we(prog_we[0]), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]),
    .init_done(init_done[0]), .dbg_state(dbg_state[0])
  );

  inst_mem_pipe #(.WIDTH(32), .DEPTH(256), .ADDR_W(32), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_pc(req_pc[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
    .rsp_pc(rsp_pc[1]), .rsp_err(rsp_err[1]),
    .prog_we(prog_we[1]), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]),
    .init_done(init_done[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic qclear(input int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  function automatic exp_t qpop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic fetch(input int d, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [1:0] err);
    exp_t e;
    bit   done;
    done         = 1'b0;
    req_valid[d] = 1'b1;
    req_pc[d]    = pc;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        e.pc = pc; e.instr = ins; e.err = err; e.acc = cyc;
        qpush(d, e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("fetch_accepted_dut%0d_pc%h", d, pc), 64'(done), 64'd1);
  endtask

  task automatic prog(input int d, input logic [7:0] a, input logic [31:0] v);
    prog_we[d] = 1'b1; prog_addr[d] = a; prog_data[d] = v;
    @(negedge clk);
    chk($sformatf("prog_blocks_req_dut%0d", d), 64'(req_ready[d]), 64'd0);
    @(posedge clk); #1;
    prog_we[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    for (int t = 0; t < 50; t++) begin
      if (qsize(d) == 0) break;
      @(posedge clk); #1;
    end
    chk($sformatf("drain_dut%0d", d), 64'(qsize(d)), 64'd0);
  endtask

  task automatic wait_init();
    int n;
    int early;
    n = 0; early = 0;
    chk("state_clear", 64'(dbg_state[0]), 64'd0);
    while (!init_done[0] && n < 1000) begin
      if (req_ready[0] || req_ready[1]) early++;
      @(posedge clk); n++; #1;
    end
    chk("init_cycles", 64'(n), 64'd256);
    chk("ready_low_in_clear", 64'(early), 64'd0);
    chk("init_done_dut1", 64'(init_done[1]), 64'd1);
    chk("state_run", 64'(dbg_state[0]), 64'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst && rsp_valid[d] && rsp_ready[d]) begin
        if (qsize(d) == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp_dut%0d: got pc %h instr %h, required no response",
                   d, rsp_pc[d], rsp_instr[d]);
        end else begin
          e = qpop(d);
          chk($sformatf("rsp_pc_dut%0d", d), 64'(rsp_pc[d]), 64'(e.pc));
          chk($sformatf("rsp_instr_dut%0d_pc%h", d, e.pc), 64'(rsp_instr[d]), 64'(e.instr));
          chk($sformatf("rsp_err_dut%0d_pc%h", d, e.pc), 64'(rsp_err[d]), 64'(e.err));
          if (lat_chk[d])
            chk($sformatf("latency_dut%0d_pc%h", d, e.pc), 64'(cyc - int'(e.acc)), 64'(lat_of[d]));
        end
      end
    end
  end

  // ---------------- stall checker ----------------
  task automatic stall_check();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = rsp_valid[0];
    end
    chk("stall_rsp_seen", 64'(seen), 64'd1);
    for (int j = 0; j < 5; j++) begin
      chk("stall_valid_hold", 64'(rsp_valid[0]), 64'd1);
      chk("stall_pc_hold", 64'(rsp_pc[0]), 64'd0);
      chk("stall_instr_hold", 64'(rsp_instr[0]), 64'(W0));
      chk("stall_req_ready", 64'(req_ready[0]), 64'd0);
      if (j < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
    vec[0] = '{32'd0,    W0,    2'b00};
    vec[1] = '{32'd4,    W1,    2'b00};
    vec[2] = '{32'd8,    W2,    2'b00};
    vec[3] = '{32'd12,   W3,    2'b00};
    vec[4] = '{32'd6,    32'h0, 2'b01};
    vec[5] = '{32'd1024, 32'h0, 2'b10};
    vec[6] = '{32'd1025, 32'h0, 2'b11};
    vec[7] = '{32'd4,    W1,    2'b00};
    vec[8] = '{32'd8,    W2,    2'b00};
    lat_of[0] = 2; lat_of[1] = 3;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_pc[d] = '0; rsp_ready[d] = 1'b1; flush[d] = 1'b0;
      prog_we[d] = 1'b0; prog_addr[d] = '0; prog_data[d] = '0; lat_chk[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rsp_valid_dut%0d", d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("rst_rsp_instr_dut%0d", d), 64'(rsp_instr[d]), 64'd0);
      chk($sformatf("rst_rsp_pc_dut%0d", d), 64'(rsp_pc[d]), 64'd0);
      chk($sformatf("rst_rsp_err_dut%0d", d), 64'(rsp_err[d]), 64'd0);
      chk($sformatf("rst_req_ready_dut%0d", d), 64'(req_ready[d]), 64'd0);
      chk($sformatf("rst_init_done_dut%0d", d), 64'(init_done[d]), 64'd0);
    end

    // Clear sweep with a fetch already waiting, then the cleared word comes back.
    req_valid[0] = 1'b1; req_pc[0] = 32'd0;
    rst = 1'b0;
    wait_init();
    lat_chk[0] = 1'b1;
    fetch(0, 32'd0, 32'h0, 2'b00);
    req_valid[0] = 1'b0;
    wait_drain(0);

    // Program image, then table-driven back-to-back fetch stream.
    for (int i = 0; i < 4; i++) prog(0, 8'(i), words[i]);
    for (int i = 0; i < NV; i++) fetch(0, vec[i].pc, vec[i].instr, vec[i].err);
    req_valid[0] = 1'b0;
    wait_drain(0);

    // Consumer back-pressure for five cycles during a four-fetch stream.
    lat_chk[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) fetch(0, 32'(4 * i), words[i], 2'b00);
        req_valid[0] = 1'b0;
      end
      stall_check();
    join
    wait_drain(0);
    lat_chk[0] = 1'b1;

    // Program write while a fetch of the same word is in flight.
    fetch(0, 32'd8, W2, 2'b00);
    prog(0, 8'd2, NEWW);
    fetch(0, 32'd8, NEWW, 2'b00);
    req_valid[0] = 1'b0;
    wait_drain(0);

    // Flush with two fetches in flight on the LATENCY=3 instance.
    lat_chk[1] = 1'b1;
    prog(1, 8'd2, W2);
    fetch(1, 32'd0, 32'h0, 2'b00);
    fetch(1, 32'd4, 32'h0, 2'b00);
    req_pc[1] = 32'd12;
    flush[1]  = 1'b1;
    @(negedge clk);
    chk("flush_blocks_req", 64'(req_ready[1]), 64'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    req_valid[1] = 1'b0;
    qclear(1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("flush_no_rsp", 64'(rsp_valid[1]), 64'd0);
      @(posedge clk); #1;
    end
    fetch(1, 32'd8, W2, 2'b00);
    req_valid[1] = 1'b0;
    wait_drain(1);

    // Reset in the middle of a stream.
    fetch(0, 32'd0, W0, 2'b00);
    fetch(0, 32'd4, W1, 2'b00);
    chk("pre_reset_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    req_pc[0] = 32'd8;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("midrst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("midrst_init_done", 64'(init_done[0]), 64'd0);
    chk("midrst_rsp_pc", 64'(rsp_pc[0]), 64'd0);
    qclear(0);
    qclear(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init();
    fetch(0, 32'd8, 32'h0, 2'b00);
    fetch(0, 32'd12, 32'h0, 2'b00);
    req_valid[0] = 1'b0;
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
